// File: rtl/spad_pkg.sv
// Shared definitions for the SPAD readout collector.
// Holds frame geometry, the capture FSM encoding and the sample index packing order.
// Ports: none (package).
package spad_pkg;

  localparam int SPAD_IDX_W             = 10;
  localparam int SPAD_SAMPLES_PER_FRAME = 1024;
  localparam int SPAD_LANES             = 4;
  localparam int SPAD_LANE_W            = 8;
  localparam int SPAD_WORD_W            = SPAD_LANES * SPAD_LANE_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } spad_state_e;

  // Raster position of a sample: row group, then column, then half select.
  function automatic logic [SPAD_IDX_W-1:0] spad_idx(input logic [2:0] row,
                                                     input logic [5:0] col,
                                                     input logic       half);
    return {row, col, half};
  endfunction

endpackage

// File: rtl/spad_word_fifo.sv
// Synchronous word FIFO for the collector output (data plus last flag).
// Ports: clk/rst, push/push_dat (write, caller guarantees room or same-cycle pop),
//        pop (caller guarantees not empty), rd_dat straight from storage flops, full/empty.
module spad_word_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_dat,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty  = (wr_q == rd_q);
  assign full   = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign rd_dat = mem_q[rd_q[AW-1:0]];

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (push) begin
      mem_d[wr_q[AW-1:0]] = push_dat;
      wr_d                = wr_q + PTR_ONE;
    end
    if (pop) begin
      rd_d = rd_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
    end
  end

endmodule

// File: rtl/spad_readout_collector.sv
// SPAD readout collector: samples PixelData once per read window, packs 4 samples per
// 32-bit word in raster order and streams words out over AXI4-Stream (TLAST at idx 1023).
// Ports: clk/reset, read manager strobes (ReadEnable/RowSelect/ColSelect/HighLowRows),
//        PixelData, m_axis_* master, sticky overflow, frame_count.
// Optional: define SPAD_COLLECTOR_SEQ_CHECK_EN to add the index sequence checker (seq_err).
module spad_readout_collector
  import spad_pkg::*;
#(
  parameter int PIXEL_WIDTH  = 8,
  parameter int SAMPLE_DELAY = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ReadEnable,
  input  logic [2:0]             RowSelect,
  input  logic [5:0]             ColSelect,
  input  logic                   HighLowRows,
  input  logic [PIXEL_WIDTH-1:0] PixelData,
  output logic [31:0]            m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tlast,
  output logic                   overflow,
`ifdef SPAD_COLLECTOR_SEQ_CHECK_EN
  output logic                   seq_err,
`endif
  output logic [15:0]            frame_count
);

  localparam logic [3:0]            SD_W     = 4'(SAMPLE_DELAY);
  localparam logic [SPAD_IDX_W-1:0] LAST_IDX = {SPAD_IDX_W{1'b1}};
  localparam logic [SPAD_IDX_W-1:0] IDX_ONE  = {{(SPAD_IDX_W-1){1'b0}}, 1'b1};

  spad_state_e state_q, state_d;
  logic [3:0]  run_q, run_d;
  logic        cap_vld;

  logic [SPAD_IDX_W-1:0]  cap_idx;
  logic [SPAD_LANE_W-1:0] cap_dat;
  logic [SPAD_WORD_W-1:0] word_q, word_d;
  logic [1:0]             pos_q, pos_d, lane;
  logic                   discard;
  logic                   push, push_ok, pop;
  logic [SPAD_WORD_W:0]   push_dat, rd_dat;
  logic                   fifo_full, fifo_empty;
  logic                   overflow_q, overflow_d;
  logic [15:0]            frame_q, frame_d;
`ifdef SPAD_COLLECTOR_SEQ_CHECK_EN
  logic [SPAD_IDX_W-1:0]  exp_q, exp_d;
  logic                   seq_err_q, seq_err_d;
`endif

  // Capture FSM: one sample per window, on the SAMPLE_DELAY-th high cycle.
  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    cap_vld = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ReadEnable) begin
          run_d = 4'd1;
          if (SD_W == 4'd1) begin
            cap_vld = 1'b1;
            state_d = ST_HOLD;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (!ReadEnable) begin
          state_d = ST_IDLE;
        end else begin
          run_d = run_q + 4'd1;
          if (run_d == SD_W) begin
            cap_vld = 1'b1;
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (!ReadEnable) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign cap_idx = spad_idx(RowSelect, ColSelect, HighLowRows);
  assign cap_dat = PixelData[SPAD_LANE_W-1:0];

  // Lane packing, frame-start abort and (optionally) index resync.
  always_comb begin
    word_d   = word_q;
    pos_d    = pos_q;
    lane     = pos_q;
    discard  = 1'b0;
    push     = 1'b0;
    push_dat = '0;
`ifdef SPAD_COLLECTOR_SEQ_CHECK_EN
    exp_d     = exp_q;
    seq_err_d = seq_err_q;
`endif
    if (cap_vld) begin
      // idx 0 always starts a fresh word; anything partial is an upstream abort.
      if (cap_idx == '0) begin
        lane    = 2'd0;
        discard = (pos_q != 2'd0);
      end
`ifdef SPAD_COLLECTOR_SEQ_CHECK_EN
      if (cap_idx != exp_q && cap_idx != '0) begin
        discard   = 1'b1;
        lane      = cap_idx[1:0];
        seq_err_d = 1'b1;
      end
      exp_d = cap_idx + IDX_ONE;
`endif
      if (discard) word_d = '0;
      word_d[{lane, 3'b000} +: SPAD_LANE_W] = cap_dat;
      if (lane == 2'd3) begin
        push     = 1'b1;
        push_dat = {(cap_idx == LAST_IDX), word_d};
        word_d   = '0;
        pos_d    = 2'd0;
      end else begin
        pos_d = lane + 2'd1;
      end
    end
  end

  // A full FIFO still takes the word when the head leaves in the same cycle.
  assign pop     = m_axis_tready && !fifo_empty;
  assign push_ok = push && (!fifo_full || pop);

  always_comb begin
    overflow_d = overflow_q | (push && !push_ok);
    frame_d    = frame_q;
    if (push_ok && push_dat[SPAD_WORD_W]) frame_d = frame_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      run_q      <= '0;
      word_q     <= '0;
      pos_q      <= '0;
      overflow_q <= 1'b0;
      frame_q    <= '0;
`ifdef SPAD_COLLECTOR_SEQ_CHECK_EN
      exp_q      <= '0;
      seq_err_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      run_q      <= run_d;
      word_q     <= word_d;
      pos_q      <= pos_d;
      overflow_q <= overflow_d;
      frame_q    <= frame_d;
`ifdef SPAD_COLLECTOR_SEQ_CHECK_EN
      exp_q      <= exp_d;
      seq_err_q  <= seq_err_d;
`endif
    end
  end

  spad_word_fifo #(
    .WIDTH(SPAD_WORD_W + 1),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .push    (push_ok),
    .push_dat(push_dat),
    .pop     (pop),
    .rd_dat  (rd_dat),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign m_axis_tdata  = rd_dat[SPAD_WORD_W-1:0];
  assign m_axis_tlast  = rd_dat[SPAD_WORD_W];
  assign m_axis_tvalid = !fifo_empty;
  assign overflow      = overflow_q;
  assign frame_count   = frame_q;
`ifdef SPAD_COLLECTOR_SEQ_CHECK_EN
  assign seq_err       = seq_err_q;
`endif

endmodule
